// File: rtl/ps2_device.sv
// PS/2 device-side endpoint: generates the PS/2 clock, sends device-to-host
// frames (start, d0..d7, odd parity, stop) and receives host-to-device
// commands after a request-to-send, acknowledging frames with good parity.
module ps2_device #(
  parameter int HALF_CYCLES = 2000,
  parameter int IDLE_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_d,
  input  logic       ps2_data_d,
  output logic       ps2_clk_q,
  output logic       ps2_data_q,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error
);

  localparam int HCW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam int ICW = $clog2(IDLE_CYCLES + 1);
  localparam logic [HCW-1:0] HC_LAST = HCW'(HALF_CYCLES - 1);
  localparam logic [HCW-1:0] HC_INH  = HCW'(3);
  localparam logic [ICW-1:0] IC_MAX  = ICW'(IDLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX      = 3'd1,
    S_TX_TAIL = 3'd2,
    S_RX      = 3'd3,
    S_RX_ACK  = 3'd4,
    S_RX_TAIL = 3'd5
  } state_t;

  logic [1:0]     clk_sync_q;
  logic [1:0]     data_sync_q;
  logic [ICW-1:0] idle_cnt_q;
  state_t         state_q;
  logic [HCW-1:0] hcnt_q;
  logic           phase_low_q;
  logic [3:0]     bit_cnt_q;
  logic [7:0]     tx_byte_q;
  logic           tx_busy_q;
  logic           tx_armed_q;
  logic [9:0]     rx_shift_q;
  logic [7:0]     rx_data_q;
  logic           rx_ready_q;
  logic           rx_error_q;
  logic           clk_drv_q;
  logic           data_drv_q;

  logic line_clk;
  logic line_data;
  logic bus_idle;
  logic half_end;

  assign line_clk  = clk_sync_q[1];
  assign line_data = data_sync_q[1];
  assign bus_idle  = (idle_cnt_q == IC_MAX);
  assign half_end  = (hcnt_q == HC_LAST);

  assign ps2_clk_q  = clk_drv_q;
  assign ps2_data_q = data_drv_q;
  assign tx_busy    = tx_busy_q;
  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign rx_error   = rx_error_q;

  // Odd parity over a data byte.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Line level of frame bit idx (0 = start ... 10 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [10:0] f;
    f = {1'b1, odd_parity(b), b, 1'b0};
    if (idx > 4'd10) begin
      return 1'b1;
    end else begin
      return f[idx];
    end
  endfunction

  // Two-flop synchronisers for both PS/2 pins (idle level is high).
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_d};
      data_sync_q <= {data_sync_q[0], ps2_data_d};
    end
  end

  // Saturating counter of cycles with both synced lines high.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else if (!(line_clk && line_data)) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != IC_MAX) begin
      idle_cnt_q <= idle_cnt_q + ICW'(1);
    end else begin
      idle_cnt_q <= idle_cnt_q;
    end
  end

  // Protocol FSM: idle arbitration, transmit, receive and acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hcnt_q      <= '0;
      phase_low_q <= 1'b0;
      bit_cnt_q   <= 4'd0;
      tx_byte_q   <= 8'h00;
      tx_busy_q   <= 1'b0;
      tx_armed_q  <= 1'b0;
      rx_shift_q  <= 10'h000;
      rx_data_q   <= 8'h00;
      rx_ready_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      clk_drv_q   <= 1'b1;
      data_drv_q  <= 1'b1;
    end else begin
      rx_ready_q <= 1'b0;
      rx_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_drv_q   <= 1'b1;
          data_drv_q  <= 1'b1;
          hcnt_q      <= '0;
          phase_low_q <= 1'b0;
          bit_cnt_q   <= 4'd0;
          if (tx_req && !tx_busy_q) begin
            tx_byte_q <= tx_data;
            tx_busy_q <= 1'b1;
          end
          // Launch one cycle after the latch so an RTS that arrived with the
          // request (still inside the synchroniser) gets priority.
          tx_armed_q <= tx_busy_q;
          if (!line_data && line_clk) begin
            state_q <= S_RX;
          end else if (tx_busy_q && tx_armed_q && bus_idle) begin
            state_q    <= S_TX;
            data_drv_q <= 1'b0;
          end
        end
        S_TX: begin
          if (clk_drv_q && !line_clk && (hcnt_q >= HC_INH) && (bit_cnt_q < 4'd9)) begin
            // Host inhibit: abandon the frame but keep the byte for a resend.
            clk_drv_q  <= 1'b1;
            data_drv_q <= 1'b1;
            hcnt_q     <= '0;
            state_q    <= S_IDLE;
          end else if (half_end) begin
            hcnt_q <= '0;
            if (!phase_low_q) begin
              phase_low_q <= 1'b1;
              clk_drv_q   <= 1'b0;
            end else if (bit_cnt_q == 4'd10) begin
              phase_low_q <= 1'b0;
              clk_drv_q   <= 1'b1;
              data_drv_q  <= 1'b1;
              state_q     <= S_TX_TAIL;
            end else begin
              phase_low_q <= 1'b0;
              clk_drv_q   <= 1'b1;
              bit_cnt_q   <= bit_cnt_q + 4'd1;
              data_drv_q  <= frame_bit(tx_byte_q, bit_cnt_q + 4'd1);
            end
          end else begin
            hcnt_q <= hcnt_q + HCW'(1);
          end
        end
        S_TX_TAIL: begin
          if (half_end) begin
            hcnt_q    <= '0;
            tx_busy_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            hcnt_q <= hcnt_q + HCW'(1);
          end
        end
        S_RX: begin
          if (half_end) begin
            hcnt_q <= '0;
            if (!phase_low_q) begin
              rx_shift_q  <= {line_data, rx_shift_q[9:1]};
              phase_low_q <= 1'b1;
              clk_drv_q   <= 1'b0;
            end else if (bit_cnt_q == 4'd9) begin
              phase_low_q <= 1'b0;
              clk_drv_q   <= 1'b1;
              if (rx_shift_q[9] && (rx_shift_q[8] == odd_parity(rx_shift_q[7:0]))) begin
                data_drv_q <= 1'b0;
                state_q    <= S_RX_ACK;
              end else begin
                rx_error_q <= 1'b1;
                state_q    <= S_RX_TAIL;
              end
            end else begin
              phase_low_q <= 1'b0;
              clk_drv_q   <= 1'b1;
              bit_cnt_q   <= bit_cnt_q + 4'd1;
            end
          end else begin
            hcnt_q <= hcnt_q + HCW'(1);
          end
        end
        S_RX_ACK: begin
          if (half_end) begin
            hcnt_q <= '0;
            if (!phase_low_q) begin
              phase_low_q <= 1'b1;
              clk_drv_q   <= 1'b0;
            end else begin
              phase_low_q <= 1'b0;
              clk_drv_q   <= 1'b1;
              data_drv_q  <= 1'b1;
              rx_data_q   <= rx_shift_q[7:0];
              rx_ready_q  <= 1'b1;
              state_q     <= S_RX_TAIL;
            end
          end else begin
            hcnt_q <= hcnt_q + HCW'(1);
          end
        end
        S_RX_TAIL: begin
          if (half_end) begin
            hcnt_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            hcnt_q <= hcnt_q + HCW'(1);
          end
        end
        default: begin
          clk_drv_q  <= 1'b1;
          data_drv_q <= 1'b1;
          hcnt_q     <= '0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device.sv
// Directed testbench for ps2_device with a host model on pulled-up lines.
module tb_ps2_device;

  logic       clk;
  logic       reset;
  logic       host_clk;
  logic       host_data;
  logic       ps2_clk_q;
  logic       ps2_data_q;
  logic       ps2_clk_line;
  logic       ps2_data_line;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_error;

  int n_chk;
  int n_err;

  // Open-drain bus with pullups: either end can pull low.
  assign ps2_clk_line  = ps2_clk_q & host_clk;
  assign ps2_data_line = ps2_data_q & host_data;

  ps2_device #(.HALF_CYCLES(8), .IDLE_CYCLES(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_d  (ps2_clk_line),
    .ps2_data_d (ps2_data_line),
    .ps2_clk_q  (ps2_clk_q),
    .ps2_data_q (ps2_data_q),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_error   (rx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for the next falling edge of the device clock drive (bounded).
  task automatic wait_fall(output bit ok);
    logic prev;
    prev = ps2_clk_q;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (prev === 1'b1 && ps2_clk_q === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = ps2_clk_q;
    end
  endtask

  // Host receiver: wait for a start bit, then record data at each clock
  // falling edge and count cycles tx_busy stays high from TX entry.
  // A second tx_req is pulsed poke_at cycles after the start bit (if >= 0).
  task automatic tx_frame(input int poke_at, output logic [10:0] bits,
                          output int nbits, output int busy_cnt, output int wait_cyc);
    logic prev;
    int t;
    bits = 11'h000;
    nbits = 0;
    busy_cnt = 0;
    wait_cyc = 0;
    while (ps2_data_q !== 1'b0 && wait_cyc < 400) begin
      step();
      wait_cyc++;
    end
    prev = ps2_clk_q;
    t = 0;
    while (tx_busy === 1'b1 && t < 400) begin
      busy_cnt++;
      if (t == poke_at) begin
        tx_req  = 1'b1;
        tx_data = 8'h5A;
      end else begin
        tx_req = 1'b0;
      end
      step();
      t++;
      if (prev === 1'b1 && ps2_clk_q === 1'b0 && nbits < 11) begin
        bits[nbits] = ps2_data_q;
        nbits++;
      end
      prev = ps2_clk_q;
    end
    tx_req = 1'b0;
  endtask

  // Host transmitter: RTS, then present each bit after a device clock fall.
  task automatic rx_send(input logic [7:0] b, input logic par, input logic stp,
                         input bit with_tx, input logic [7:0] txb);
    logic [9:0] f;
    bit ok;
    bit all_ok;
    f = {stp, par, b};
    all_ok = 1'b1;
    host_data = 1'b0;
    if (with_tx) begin
      tx_req  = 1'b1;
      tx_data = txb;
    end
    step();
    tx_req = 1'b0;
    repeat (4) step();
    host_data = f[0];
    for (int i = 1; i < 10; i++) begin
      wait_fall(ok);
      if (!ok) all_ok = 1'b0;
      host_data = f[i];
    end
    wait_fall(ok);
    if (!ok) all_ok = 1'b0;
    host_data = 1'b1;
    chk("rx_ten_clocks", all_ok, 1'b1);
  endtask

  logic [10:0] bits;
  int nbits, busy_cnt, wait_cyc;
  int cnt_a, cnt_b, cnt_c, nf;
  bit ok;
  logic prev;

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    host_clk = 1'b1;
    host_data = 1'b1;
    tx_req = 1'b0;
    tx_data = 8'h00;
    repeat (3) step();
    chk("rst_clk", ps2_clk_q, 1'b1);
    chk("rst_data", ps2_data_q, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_rdy_err", {rx_ready, rx_error}, 2'b00);
    chk("rst_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    repeat (30) step();

    // 0x1C has three ones: parity bit 0. Busy = 11*16 + 8 = 184 cycles.
    tx_req = 1'b1;
    tx_data = 8'h1C;
    step();
    tx_req = 1'b0;
    chk("tx1c_busy_set", tx_busy, 1'b1);
    tx_frame(-1, bits, nbits, busy_cnt, wait_cyc);
    chk("tx1c_nbits", nbits, 11);
    chk("tx1c_frame", bits, {1'b1, 1'b0, 8'h1C, 1'b0});
    chk("tx1c_busy_len", busy_cnt, 184);

    // 0x00: parity bit 1; a second request mid-frame must be dropped.
    repeat (5) step();
    tx_req = 1'b1;
    tx_data = 8'h00;
    step();
    tx_req = 1'b0;
    tx_frame(50, bits, nbits, busy_cnt, wait_cyc);
    chk("tx00_nbits", nbits, 11);
    chk("tx00_frame", bits, {1'b1, 1'b1, 8'h00, 1'b0});
    chk("tx00_busy_len", busy_cnt, 184);
    cnt_a = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ps2_data_q === 1'b0 || tx_busy === 1'b1) cnt_a++;
    end
    chk("tx00_no_second_frame", cnt_a, 0);

    // 0xAA inhibited during the high phase of d3 (after 4 clock falls).
    repeat (5) step();
    tx_req = 1'b1;
    tx_data = 8'hAA;
    step();
    tx_req = 1'b0;
    nf = 0;
    prev = ps2_clk_q;
    for (int n = 0; n < 400 && nf < 4; n++) begin
      step();
      if (prev === 1'b1 && ps2_clk_q === 1'b0) nf++;
      prev = ps2_clk_q;
    end
    chk("txaa_four_falls", nf, 4);
    repeat (9) step();
    host_clk = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ps2_clk_q === 1'b0 || ps2_data_q === 1'b0) cnt_a++;
    end
    chk("txaa_lines_released", cnt_a, 0);
    chk("txaa_busy_kept", tx_busy, 1'b1);
    host_clk = 1'b1;
    // Restart: 2 sync cycles + 20 idle cycles + 1 launch cycle.
    tx_frame(-1, bits, nbits, busy_cnt, wait_cyc);
    chk("txaa_resend_delay", wait_cyc, 23);
    chk("txaa_nbits", nbits, 11);
    chk("txaa_frame", bits, {1'b1, 1'b1, 8'hAA, 1'b0});
    chk("txaa_busy_len", busy_cnt, 184);

    // Host sends 0xED (six ones, odd parity bit 1): expect ack and rx_ready.
    repeat (30) step();
    rx_send(8'hED, 1'b1, 1'b1, 1'b0, 8'h00);
    wait_fall(ok);
    chk("rxed_11th_clock", ok, 1'b1);
    chk("rxed_ack_low", ps2_data_q, 1'b0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rx_ready === 1'b1) cnt_a++;
      if (rx_error === 1'b1) cnt_b++;
    end
    chk("rxed_ready_pulse", cnt_a, 1);
    chk("rxed_no_error", cnt_b, 0);
    chk("rxed_data", rx_data, 8'hED);

    // Host sends 0xF4 (five ones, correct parity 0) with parity 1.
    repeat (30) step();
    rx_send(8'hF4, 1'b1, 1'b1, 1'b0, 8'h00);
    cnt_a = 0;
    cnt_b = 0;
    cnt_c = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rx_ready === 1'b1) cnt_a++;
      if (rx_error === 1'b1) cnt_b++;
      if (ps2_data_q === 1'b0) cnt_c++;
    end
    chk("rxf4_no_ready", cnt_a, 0);
    chk("rxf4_error_pulse", cnt_b, 1);
    chk("rxf4_no_ack", cnt_c, 0);
    chk("rxf4_data_kept", rx_data, 8'hED);

    // RTS (0xF0, parity 1) in the same cycle as tx_req 0x3B (parity 0).
    repeat (30) step();
    rx_send(8'hF0, 1'b1, 1'b1, 1'b1, 8'h3B);
    chk("race_busy_held", tx_busy, 1'b1);
    wait_fall(ok);
    chk("race_ack_low", ps2_data_q, 1'b0);
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rx_ready === 1'b1) cnt_a++;
    end
    chk("race_ready_pulse", cnt_a, 1);
    chk("race_rx_data", rx_data, 8'hF0);
    tx_frame(-1, bits, nbits, busy_cnt, wait_cyc);
    chk("race_tx_frame", bits, {1'b1, 1'b0, 8'h3B, 1'b0});
    chk("race_busy_len", busy_cnt, 184);

    // Reset during the low phase of d0 releases both lines next edge.
    repeat (5) step();
    tx_req = 1'b1;
    tx_data = 8'h55;
    step();
    tx_req = 1'b0;
    cnt_a = 0;
    while (ps2_data_q !== 1'b0 && cnt_a < 100) begin
      step();
      cnt_a++;
    end
    repeat (26) step();
    chk("midrst_clk_low_before", ps2_clk_q, 1'b0);
    reset = 1'b1;
    step();
    chk("midrst_lines", {ps2_clk_q, ps2_data_q}, 2'b11);
    chk("midrst_busy", tx_busy, 1'b0);
    reset = 1'b0;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
